fpga_tile_cfg: RTL

- Parametrised successor to the fixed 4-bit, single-LUT fabric tile.
- Adds generic channel width `W`, generic LUT size `K` and `N_LE` logic elements per tile.
- Replaces the parallel config word with a serial configuration chain loaded through a valid/ready handshake. The chain is shadow-buffered so a new configuration is committed atomically.
- Instantiated in arrays as the basic programmable cell; tiles are configured one at a time by the fabric config controller.

---
 rtl/fpga_tile_cfg.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/fpga_tile_cfg.sv
// fpga_tile_cfg: routing tile with N_LE K-input LUT elements and a shadow-buffered serial config chain.
// Ports: clk, rst_n (async, active-low); {north,south,east,west}_{in,out} [W]; cfg_start/valid/data in; cfg_ready/busy/done out.
module fpga_tile_cfg #(
  parameter int W    = 4,
  parameter int K    = 4,
  parameter int N_LE = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] north_in,
  input  logic [W-1:0] south_in,
  input  logic [W-1:0] east_in,
  input  logic [W-1:0] west_in,
  output logic [W-1:0] north_out,
  output logic [W-1:0] south_out,
  output logic [W-1:0] east_out,
  output logic [W-1:0] west_out,
  input  logic         cfg_start,
  input  logic         cfg_valid,
  input  logic         cfg_data,
  output logic         cfg_ready,
  output logic         cfg_busy,
  output logic         cfg_done
);

  localparam int NI      = 4 * W;
  localparam int SEL_W   = $clog2(NI);
  localparam int OSEL_W  = (N_LE > 1) ? $clog2(N_LE) : 1;
  localparam int MK      = 1 << K;
  localparam int LE_CFG  = K * SEL_W + MK + 2;
  localparam int OF_W    = 2 + OSEL_W;
  localparam int CFG_LEN = N_LE * LE_CFG + NI * OF_W;
  localparam int CNT_W   = $clog2(CFG_LEN + 1);
  localparam int IP      = 1 << SEL_W;
  localparam int LP      = 1 << OSEL_W;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    COMMIT
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt;
  logic [CFG_LEN-1:0]   shadow;
  logic [CFG_LEN-1:0]   active;
  logic                 done_q;
  logic                 commit;
  logic                 accept;
  logic                 last;

  logic [NI-1:0]        in_bus;
  logic [IP-1:0]        in_pad;
  logic [NI-1:0]        out_bus;
  logic [N_LE-1:0]      le_out;
  logic [LP-1:0]        le_pad;
  logic [LP-1:0]        le_ok;

  assign accept = cfg_valid & cfg_ready;
  assign last   = (cnt == CNT_W'(CFG_LEN - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (cfg_start) state_d = SHIFT;
      SHIFT:   if (accept && last) state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cfg_ready = (state_q == SHIFT);
    cfg_busy  = (state_q != IDLE);
    commit    = (state_q == COMMIT);
  end

  assign cfg_done = done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      shadow <= '0;
      active <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= commit;
      if (commit) active <= shadow;
      if (accept) begin
        shadow <= {shadow[CFG_LEN-2:0], cfg_data};
        cnt    <= cnt + CNT_W'(1);
      end else if (state_q == IDLE && cfg_start) begin
        cnt <= '0;
      end
    end
  end

  assign in_bus = {west_in, east_in, south_in, north_in};
  // Zero-padded so any select beyond the real inputs reads 0.
  assign in_pad = IP'(in_bus);
  assign le_pad = LP'(le_out);
  assign le_ok  = LP'({N_LE{1'b1}});

  for (genvar i = 0; i < N_LE; i++) begin : g_le
    localparam int B = i * LE_CFG;
    logic [K-1:0]  lin;
    logic [MK-1:0] mask;
    logic          use_ff;
    logic          lut;
    logic          ff_q;

    for (genvar j = 0; j < K; j++) begin : g_in
      assign lin[j] = in_pad[active[B + j * SEL_W +: SEL_W]];
    end

    assign mask   = active[B + K * SEL_W +: MK];
    assign use_ff = active[B + K * SEL_W + MK];
    assign lut    = mask[lin];

    // The commit edge seeds the FF from the incoming config.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      ff_q <= 1'b0;
      else if (commit) ff_q <= shadow[B + K * SEL_W + MK + 1];
      else             ff_q <= lut;
    end

    assign le_out[i] = use_ff ? ff_q : lut;
  end

  for (genvar o = 0; o < NI; o++) begin : g_out
    localparam int OB  = N_LE * LE_CFG + o * OF_W;
    localparam int OPP = ((o / W) ^ 1) * W + (o % W);
    logic [1:0]        mode;
    logic [OSEL_W-1:0] osel;
    logic              ok;
    logic              ob;

    assign mode = active[OB +: 2];
    assign osel = active[OB + 2 +: OSEL_W];
    assign ok   = le_ok[osel];

    always_comb begin
      unique case (1'b1)
        mode == 2'b01: ob = le_pad[osel] & ok;
        mode == 2'b10: ob = in_bus[OPP];
        mode == 2'b11: ob = ~le_pad[osel] & ok;
        default:       ob = 1'b0;
      endcase
    end

    assign out_bus[o] = ob;
  end

  assign north_out = out_bus[0 * W +: W];
  assign south_out = out_bus[1 * W +: W];
  assign east_out  = out_bus[2 * W +: W];
  assign west_out  = out_bus[3 * W +: W];

endmodule
